pong_pixel_renderer: RTL and testbench

- Downstream consumer of the Pong game state machine.
- Takes per-pixel coordinates and syncs from the VGA timing generator, plus ball/paddle positions, score digits and finish flag from the game FSM.
- Produces registered 12-bit RGB with syncs delayed to match.
- Game state is snapshotted once per frame so a frame never tears mid-scan.

---
 rtl/pong_pixel_renderer.sv | 244 ++++++++++++++++++++++++
 tb/tb_pong_pixel_renderer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_pixel_renderer.sv
// Pong pixel renderer: per-frame snapshot of game state, 2-stage pipeline to registered 12-bit RGB.
// Optional macro PONG_RENDER_SCANLINE_EN halves every colour channel on odd rows.
module pong_pixel_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 80,
  parameter int PADDLE1_X = 16,
  parameter int PADDLE2_X = 608,
  parameter int NET_X     = 314,
  parameter int DIGIT_Y   = 16,
  parameter int SEG_T     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [9:0]         i_x,
  input  logic [9:0]         i_y,
  input  logic               i_active,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_frame_tick,
  input  logic signed [10:0] i_ball_x,
  input  logic signed [10:0] i_ball_y,
  input  logic signed [10:0] i_paddle1_y,
  input  logic signed [10:0] i_paddle2_y,
  input  logic [3:0]         i_score_p1d1,
  input  logic [3:0]         i_score_p1d2,
  input  logic [3:0]         i_score_p2d1,
  input  logic [3:0]         i_score_p2d2,
  input  logic               i_finish,
  output logic [3:0]         o_red,
  output logic [3:0]         o_green,
  output logic [3:0]         o_blue,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_active
);

  localparam int DIGIT_W = 16;
  localparam int DIGIT_H = 32;
  localparam int NET_W   = 4;
  localparam int P1D1_X  = 232;
  localparam int P1D2_X  = 252;
  localparam int P2D1_X  = 364;
  localparam int P2D2_X  = 384;

  localparam logic [4:0] Y_TOP_END   = 5'(SEG_T);
  localparam logic [4:0] Y_BOT_START = 5'(DIGIT_H - SEG_T);
  localparam logic [4:0] Y_MID_LO    = 5'(DIGIT_H / 2 - SEG_T / 2);
  localparam logic [4:0] Y_MID_HI    = 5'(DIGIT_H / 2 + SEG_T / 2);
  localparam logic [4:0] Y_HALF      = 5'(DIGIT_H / 2);
  localparam logic [3:0] X_LEFT_END  = 4'(SEG_T);
  localparam logic [3:0] X_RIGHT_BEG = 4'(DIGIT_W - SEG_T);

  // Signed half-open span test, widened to 12 bits so lo+len never wraps.
  function automatic logic inSpan(input logic signed [11:0] p, input logic signed [11:0] lo,
                                  input int len);
    logic signed [11:0] hi;
    hi = lo + 12'(len);
    return (p >= lo) && (p < hi);
  endfunction

  logic               r_tickQ;
  logic               w_tickRise;
  logic signed [10:0] r_ballX, r_ballY, r_pad1Y, r_pad2Y;
  logic [3:0]         r_p1d1, r_p1d2, r_p2d1, r_p2d2;
  logic               r_finish;

  assign w_tickRise = i_frame_tick & ~r_tickQ;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tickQ  <= 1'b0;
      r_ballX  <= 11'sd312;
      r_ballY  <= 11'sd236;
      r_pad1Y  <= 11'sd200;
      r_pad2Y  <= 11'sd200;
      r_p1d1   <= 4'd0;
      r_p1d2   <= 4'd0;
      r_p2d1   <= 4'd0;
      r_p2d2   <= 4'd0;
      r_finish <= 1'b0;
    end else begin
      r_tickQ <= i_frame_tick;
      if (w_tickRise) begin
        r_ballX  <= i_ball_x;
        r_ballY  <= i_ball_y;
        r_pad1Y  <= i_paddle1_y;
        r_pad2Y  <= i_paddle2_y;
        r_p1d1   <= i_score_p1d1;
        r_p1d2   <= i_score_p1d2;
        r_p2d1   <= i_score_p2d1;
        r_p2d2   <= i_score_p2d2;
        r_finish <= i_finish;
      end
    end
  end

  logic signed [11:0] w_px, w_py;
  logic w_inFrame, w_hitBall, w_hitPad1, w_hitPad2, w_hitNet, w_inDigitRow;
  assign w_px = {2'b00, i_x};
  assign w_py = {2'b00, i_y};
  assign w_inFrame = (i_x < 10'(H_ACTIVE)) && (i_y < 10'(V_ACTIVE));
  assign w_hitBall = inSpan(w_px, {r_ballX[10], r_ballX}, BALL_SIZE) &&
                     inSpan(w_py, {r_ballY[10], r_ballY}, BALL_SIZE);
  assign w_hitPad1 = inSpan(w_px, 12'(PADDLE1_X), PADDLE_W) &&
                     inSpan(w_py, {r_pad1Y[10], r_pad1Y}, PADDLE_H);
  assign w_hitPad2 = inSpan(w_px, 12'(PADDLE2_X), PADDLE_W) &&
                     inSpan(w_py, {r_pad2Y[10], r_pad2Y}, PADDLE_H);
  assign w_hitNet  = inSpan(w_px, 12'(NET_X), NET_W) && !i_y[4];
  assign w_inDigitRow = inSpan(w_py, 12'(DIGIT_Y), DIGIT_H);

  logic       w_digHit, w_digBlank;
  logic [3:0] w_digVal, w_digLx;

  // Tens digits blank on zero; units always drawn; finish hides all four.
  always_comb begin
    w_digHit   = 1'b0;
    w_digBlank = 1'b1;
    w_digVal   = 4'd0;
    w_digLx    = 4'd0;
    if (w_inDigitRow) begin
      if (inSpan(w_px, 12'(P1D1_X), DIGIT_W)) begin
        w_digHit = 1'b1; w_digVal = r_p1d1; w_digBlank = (r_p1d1 == 4'd0);
        w_digLx  = 4'(i_x - 10'(P1D1_X));
      end else if (inSpan(w_px, 12'(P1D2_X), DIGIT_W)) begin
        w_digHit = 1'b1; w_digVal = r_p1d2; w_digBlank = 1'b0;
        w_digLx  = 4'(i_x - 10'(P1D2_X));
      end else if (inSpan(w_px, 12'(P2D1_X), DIGIT_W)) begin
        w_digHit = 1'b1; w_digVal = r_p2d1; w_digBlank = (r_p2d1 == 4'd0);
        w_digLx  = 4'(i_x - 10'(P2D1_X));
      end else if (inSpan(w_px, 12'(P2D2_X), DIGIT_W)) begin
        w_digHit = 1'b1; w_digVal = r_p2d2; w_digBlank = 1'b0;
        w_digLx  = 4'(i_x - 10'(P2D2_X));
      end
    end
    if (r_finish) w_digBlank = 1'b1;
  end

  logic       r_s1Active, r_s1Hs, r_s1Vs;
  logic       r_s1Ball, r_s1Pad1, r_s1Pad2, r_s1Net, r_s1Digit;
  logic [3:0] r_s1DigVal, r_s1Lx;
  logic [4:0] r_s1Ly;
`ifdef PONG_RENDER_SCANLINE_EN
  logic       r_s1Odd;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1Active <= 1'b0;
      r_s1Hs     <= 1'b1;
      r_s1Vs     <= 1'b1;
      r_s1Ball   <= 1'b0;
      r_s1Pad1   <= 1'b0;
      r_s1Pad2   <= 1'b0;
      r_s1Net    <= 1'b0;
      r_s1Digit  <= 1'b0;
      r_s1DigVal <= 4'd0;
      r_s1Lx     <= 4'd0;
      r_s1Ly     <= 5'd0;
`ifdef PONG_RENDER_SCANLINE_EN
      r_s1Odd    <= 1'b0;
`endif
    end else begin
      r_s1Active <= i_active;
      r_s1Hs     <= i_hsync;
      r_s1Vs     <= i_vsync;
      r_s1Ball   <= w_inFrame && w_hitBall;
      r_s1Pad1   <= w_inFrame && w_hitPad1;
      r_s1Pad2   <= w_inFrame && w_hitPad2;
      r_s1Net    <= w_inFrame && w_hitNet;
      r_s1Digit  <= w_inFrame && w_digHit && !w_digBlank;
      r_s1DigVal <= w_digVal;
      r_s1Lx     <= w_digLx;
      r_s1Ly     <= 5'(i_y - 10'(DIGIT_Y));
`ifdef PONG_RENDER_SCANLINE_EN
      r_s1Odd    <= i_y[0];
`endif
    end
  end

  logic [6:0]  w_segs, w_segArea;
  logic        w_digitPix;
  logic [11:0] w_colour;

  // Segment order {a,b,c,d,e,f,g}; 10-15 decode to blank.
  always_comb begin
    w_segs = 7'b0000000;
    case (r_s1DigVal)
      4'd0: w_segs = 7'b1111110;
      4'd1: w_segs = 7'b0110000;
      4'd2: w_segs = 7'b1101101;
      4'd3: w_segs = 7'b1111001;
      4'd4: w_segs = 7'b0110011;
      4'd5: w_segs = 7'b1011011;
      4'd6: w_segs = 7'b1011111;
      4'd7: w_segs = 7'b1110000;
      4'd8: w_segs = 7'b1111111;
      4'd9: w_segs = 7'b1111011;
      default: w_segs = 7'b0000000;
    endcase
  end

  assign w_segArea = {
    r_s1Ly < Y_TOP_END,
    (r_s1Lx >= X_RIGHT_BEG) && (r_s1Ly < Y_HALF),
    (r_s1Lx >= X_RIGHT_BEG) && (r_s1Ly >= Y_HALF),
    r_s1Ly >= Y_BOT_START,
    (r_s1Lx < X_LEFT_END) && (r_s1Ly >= Y_HALF),
    (r_s1Lx < X_LEFT_END) && (r_s1Ly < Y_HALF),
    (r_s1Ly >= Y_MID_LO) && (r_s1Ly < Y_MID_HI)
  };
  assign w_digitPix = r_s1Digit && |(w_segs & w_segArea);

  always_comb begin
    w_colour = 12'h000;
    if (r_s1Ball || r_s1Pad1 || r_s1Pad2 || w_digitPix) w_colour = 12'hFFF;
    else if (r_s1Net)                                   w_colour = 12'h888;
    if (!r_s1Active) w_colour = 12'h000;
`ifdef PONG_RENDER_SCANLINE_EN
    if (r_s1Odd) w_colour = {1'b0, w_colour[11:9], 1'b0, w_colour[7:5], 1'b0, w_colour[3:1]};
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_red    <= 4'd0;
      o_green  <= 4'd0;
      o_blue   <= 4'd0;
      o_hsync  <= 1'b1;
      o_vsync  <= 1'b1;
      o_active <= 1'b0;
    end else begin
      o_red    <= w_colour[11:8];
      o_green  <= w_colour[7:4];
      o_blue   <= w_colour[3:0];
      o_hsync  <= r_s1Hs;
      o_vsync  <= r_s1Vs;
      o_active <= r_s1Active;
    end
  end

endmodule

// File: tb/tb_pong_pixel_renderer.sv
// Directed testbench for pong_pixel_renderer: snapshot, hit rules, digits, priority, latency, reset.
// Expected colours follow PONG_RENDER_SCANLINE_EN when the bench is built with it.
module tb_pong_pixel_renderer;

`ifdef PONG_RENDER_SCANLINE_EN
  localparam bit SCANLINE = 1'b1;
`else
  localparam bit SCANLINE = 1'b0;
`endif

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic [9:0]         i_x, i_y;
  logic               i_active, i_hsync, i_vsync, i_frame_tick;
  logic signed [10:0] i_ball_x, i_ball_y, i_paddle1_y, i_paddle2_y;
  logic [3:0]         i_score_p1d1, i_score_p1d2, i_score_p2d1, i_score_p2d2;
  logic               i_finish;
  logic [3:0]         o_red, o_green, o_blue;
  logic               o_hsync, o_vsync, o_active;

  int total = 0;
  int bad   = 0;

  pong_pixel_renderer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y), .i_active(i_active),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_frame_tick(i_frame_tick),
    .i_ball_x(i_ball_x), .i_ball_y(i_ball_y),
    .i_paddle1_y(i_paddle1_y), .i_paddle2_y(i_paddle2_y),
    .i_score_p1d1(i_score_p1d1), .i_score_p1d2(i_score_p1d2),
    .i_score_p2d1(i_score_p2d1), .i_score_p2d2(i_score_p2d2),
    .i_finish(i_finish),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_active(o_active)
  );

  always #5 i_clk = ~i_clk;

  // Expected colour after optional odd-row dimming.
  function automatic logic [11:0] shade(input logic [11:0] c, input logic [9:0] y);
    logic [11:0] dim;
    dim = {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    return (SCANLINE && y[0]) ? dim : c;
  endfunction

  // Drives one pixel right after a clock edge and returns the outputs two edges later.
  task automatic drivePixel(input int x, input int y, input logic act, input logic hs,
                            input logic vs, output logic [11:0] rgb, output logic oa,
                            output logic ohs, output logic ovs);
    i_x = 10'(x); i_y = 10'(y); i_active = act; i_hsync = hs; i_vsync = vs;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    rgb = {o_red, o_green, o_blue};
    oa  = o_active;
    ohs = o_hsync;
    ovs = o_vsync;
  endtask

  task automatic frameTick();
    i_frame_tick = 1'b1;
    @(posedge i_clk); #1;
    i_frame_tick = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic setBall(input int x, input int y);
    i_ball_x = 11'(x);
    i_ball_y = 11'(y);
  endtask

  task automatic test_reset();
    int xs[8] = '{312, 16, 24, 16, 608, 258, 238, 0};
    int ys[8] = '{236, 200, 200, 280, 279, 17, 17, 5};
    logic [11:0] ex[8] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
    logic [11:0] rgb; logic oa, ohs, ovs;
    i_rst_n = 1'b0;
    i_x = 10'd0; i_y = 10'd0; i_active = 1'b1; i_hsync = 1'b0; i_vsync = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    total++; if ({o_red, o_green, o_blue} !== 12'h000) begin bad++; $display("[TB] FAIL reset_rgb got=%h want=000", {o_red, o_green, o_blue}); end
    total++; if (o_active !== 1'b0) begin bad++; $display("[TB] FAIL reset_active got=%b want=0", o_active); end
    total++; if (o_hsync !== 1'b1) begin bad++; $display("[TB] FAIL reset_hsync got=%b want=1", o_hsync); end
    total++; if (o_vsync !== 1'b1) begin bad++; $display("[TB] FAIL reset_vsync got=%b want=1", o_vsync); end
    i_rst_n = 1'b1;
    drivePixel(0, 0, 1'b1, 1'b0, 1'b1, rgb, oa, ohs, ovs);
    total++; if (rgb !== 12'h000) begin bad++; $display("[TB] FAIL origin_rgb got=%h want=000", rgb); end
    total++; if (oa !== 1'b1) begin bad++; $display("[TB] FAIL origin_active got=%b want=1", oa); end
    total++; if (ohs !== 1'b0) begin bad++; $display("[TB] FAIL origin_hsync got=%b want=0", ohs); end
    total++; if (ovs !== 1'b1) begin bad++; $display("[TB] FAIL origin_vsync got=%b want=1", ovs); end
    for (int i = 0; i < 8; i++) begin
      drivePixel(xs[i], ys[i], 1'b1, 1'b1, 1'b0, rgb, oa, ohs, ovs);
      total++;
      if (rgb !== shade(ex[i], 10'(ys[i]))) begin
        bad++;
        $display("[TB] FAIL reset_shadow[%0d] (%0d,%0d) got=%h want=%h", i, xs[i], ys[i], rgb, shade(ex[i], 10'(ys[i])));
      end
      total++; if (ovs !== 1'b0) begin bad++; $display("[TB] FAIL reset_vsync_pass[%0d] got=%b want=0", i, ovs); end
    end
  endtask

  task automatic test_ball();
    int xs[4] = '{100, 107, 108, 99};
    int ys[4] = '{50, 57, 50, 50};
    logic [11:0] ex[4] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000};
    logic [11:0] rgb; logic oa, ohs, ovs;
    setBall(100, 50);
    frameTick();
    for (int i = 0; i < 4; i++) begin
      drivePixel(xs[i], ys[i], 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
      total++;
      if (rgb !== shade(ex[i], 10'(ys[i]))) begin
        bad++;
        $display("[TB] FAIL ball[%0d] (%0d,%0d) got=%h want=%h", i, xs[i], ys[i], rgb, shade(ex[i], 10'(ys[i])));
      end
    end
  endtask

  task automatic test_back_to_back();
    int xs[6] = '{100, 99, 316, 101, 316, 316};
    int ys[6] = '{50, 50, 0, 51, 16, 2};
    logic [11:0] ex[6] = '{12'hFFF, 12'h000, 12'h888, 12'hFFF, 12'h000, 12'h888};
    logic hs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] rgb;
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk); #1;
      if (i >= 2) begin
        rgb = {o_red, o_green, o_blue};
        total++;
        if (rgb !== shade(ex[i-2], 10'(ys[i-2]))) begin
          bad++;
          $display("[TB] FAIL b2b_rgb[%0d] got=%h want=%h", i - 2, rgb, shade(ex[i-2], 10'(ys[i-2])));
        end
        total++;
        if (o_hsync !== hs[i-2]) begin bad++; $display("[TB] FAIL b2b_hsync[%0d] got=%b want=%b", i - 2, o_hsync, hs[i-2]); end
      end
      if (i < 6) begin
        i_x = 10'(xs[i]); i_y = 10'(ys[i]); i_active = 1'b1; i_hsync = hs[i]; i_vsync = 1'b1;
      end else begin
        i_active = 1'b0; i_hsync = 1'b1;
      end
    end
  endtask

  task automatic test_no_tick();
    logic [11:0] rgb; logic oa, ohs, ovs;
    setBall(300, 240);
    repeat (3) @(posedge i_clk);
    #1;
    drivePixel(100, 50, 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
    total++; if (rgb !== 12'hFFF) begin bad++; $display("[TB] FAIL notick_old got=%h want=FFF", rgb); end
    drivePixel(300, 240, 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
    total++; if (rgb !== 12'h000) begin bad++; $display("[TB] FAIL notick_new got=%h want=000", rgb); end
    frameTick();
    drivePixel(300, 240, 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
    total++; if (rgb !== 12'hFFF) begin bad++; $display("[TB] FAIL tick_new got=%h want=FFF", rgb); end
    drivePixel(100, 50, 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
    total++; if (rgb !== 12'h000) begin bad++; $display("[TB] FAIL tick_old got=%h want=000", rgb); end
  endtask

  task automatic test_clip();
    int xs[6] = '{0, 3, 4, 636, 639, 0};
    int ys[6] = '{100, 107, 100, 100, 107, 99};
    logic [11:0] ex[6] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};
    logic [11:0] rgb; logic oa, ohs, ovs;
    setBall(-4, 100);
    frameTick();
    for (int i = 0; i < 6; i++) begin
      drivePixel(xs[i], ys[i], 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
      total++;
      if (rgb !== shade(ex[i], 10'(ys[i]))) begin
        bad++;
        $display("[TB] FAIL clip[%0d] (%0d,%0d) got=%h want=%h", i, xs[i], ys[i], rgb, shade(ex[i], 10'(ys[i])));
      end
    end
  endtask

  task automatic test_digits();
    int xs[9] = '{238, 258, 265, 265, 253, 258, 258, 377, 370};
    int ys[9] = '{17, 17, 24, 40, 24, 31, 46, 24, 17};
    logic [11:0] ex[9] = '{12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000};
    int fx[4] = '{258, 377, 397, 0};
    int fy[4] = '{17, 24, 40, 100};
    logic [11:0] fex[4] = '{12'h000, 12'h000, 12'h000, 12'hFFF};
    logic [11:0] rgb; logic oa, ohs, ovs;
    i_score_p1d1 = 4'd0; i_score_p1d2 = 4'd7; i_score_p2d1 = 4'd1; i_score_p2d2 = 4'd1;
    i_finish = 1'b0;
    frameTick();
    for (int i = 0; i < 9; i++) begin
      drivePixel(xs[i], ys[i], 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
      total++;
      if (rgb !== shade(ex[i], 10'(ys[i]))) begin
        bad++;
        $display("[TB] FAIL digit[%0d] (%0d,%0d) got=%h want=%h", i, xs[i], ys[i], rgb, shade(ex[i], 10'(ys[i])));
      end
    end
    drivePixel(397, 40, 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
    total++; if (rgb !== 12'hFFF) begin bad++; $display("[TB] FAIL digit_p2d2 got=%h want=FFF", rgb); end
    i_finish = 1'b1;
    frameTick();
    for (int i = 0; i < 4; i++) begin
      drivePixel(fx[i], fy[i], 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
      total++;
      if (rgb !== shade(fex[i], 10'(fy[i]))) begin
        bad++;
        $display("[TB] FAIL finish[%0d] (%0d,%0d) got=%h want=%h", i, fx[i], fy[i], rgb, shade(fex[i], 10'(fy[i])));
      end
    end
  endtask

  task automatic test_priority();
    int xs[6] = '{16, 23, 20, 316, 316, 316};
    int ys[6] = '{200, 207, 250, 0, 1, 16};
    logic [11:0] ex[6] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h888, 12'h888, 12'h000};
    logic [11:0] rgb; logic oa, ohs, ovs;
    setBall(16, 200);
    frameTick();
    for (int i = 0; i < 6; i++) begin
      drivePixel(xs[i], ys[i], 1'b1, 1'b1, 1'b1, rgb, oa, ohs, ovs);
      total++;
      if (rgb !== shade(ex[i], 10'(ys[i]))) begin
        bad++;
        $display("[TB] FAIL prio[%0d] (%0d,%0d) got=%h want=%h", i, xs[i], ys[i], rgb, shade(ex[i], 10'(ys[i])));
      end
    end
    drivePixel(316, 0, 1'b0, 1'b1, 1'b1, rgb, oa, ohs, ovs);
    total++; if (rgb !== 12'h000) begin bad++; $display("[TB] FAIL blank_rgb got=%h want=000", rgb); end
    total++; if (oa !== 1'b0) begin bad++; $display("[TB] FAIL blank_active got=%b want=0", oa); end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] rgb; logic oa, ohs, ovs;
    drivePixel(16, 200, 1'b1, 1'b0, 1'b0, rgb, oa, ohs, ovs);
    total++; if (rgb !== 12'hFFF) begin bad++; $display("[TB] FAIL pre_reset got=%h want=FFF", rgb); end
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    total++; if ({o_red, o_green, o_blue} !== 12'h000) begin bad++; $display("[TB] FAIL mid_reset_rgb got=%h want=000", {o_red, o_green, o_blue}); end
    total++; if (o_active !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_active got=%b want=0", o_active); end
    total++; if ({o_hsync, o_vsync} !== 2'b11) begin bad++; $display("[TB] FAIL mid_reset_sync got=%b want=11", {o_hsync, o_vsync}); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_x = 10'd312; i_y = 10'd236; i_active = 1'b1; i_hsync = 1'b1; i_vsync = 1'b1;
    @(posedge i_clk); #1;
    total++; if (o_active !== 1'b0) begin bad++; $display("[TB] FAIL release_early got=%b want=0", o_active); end
    @(posedge i_clk); #1;
    total++; if (o_active !== 1'b1) begin bad++; $display("[TB] FAIL release_active got=%b want=1", o_active); end
    total++; if ({o_red, o_green, o_blue} !== 12'hFFF) begin bad++; $display("[TB] FAIL release_ball got=%h want=FFF", {o_red, o_green, o_blue}); end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_frame_tick = 1'b0;
    setBall(0, 0);
    i_paddle1_y = 11'sd200; i_paddle2_y = 11'sd200;
    i_score_p1d1 = 4'd0; i_score_p1d2 = 4'd0; i_score_p2d1 = 4'd0; i_score_p2d2 = 4'd0;
    i_finish = 1'b0;
    test_reset();
    test_ball();
    test_back_to_back();
    test_no_tick();
    test_clip();
    test_digits();
    test_priority();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
